// File: rtl/sha3_absorb_packer.sv
`default_nettype none
// ============================================================================
//  Module   : sha3_absorb_packer
//  Purpose  : Packs an AXI-Stream byte message into rate-sized blocks and
//             applies SHA-3 padding at end of message. Each block is
//             presented as a 1600-bit state word, with byte i at bits
//             [8i+7:8i], to the Keccak permutation core.
//  Ports    : ACLK, ARESETN     - clock, asynchronous active-low reset
//             S_T*              - AXI-Stream message input (TUSER = mode)
//             BLK_DATA/VALID/READY/FIRST/LAST/MODE - block output to core
//  Config   : define SHA3_KECCAK_LEGACY_PAD_EN to use the original Keccak
//             domain byte 0x01 instead of the FIPS-202 SHA-3 byte 0x06.
//  Revision : 1.0 - initial release
// ============================================================================
module sha3_absorb_packer #(
  parameter int DATA_WIDTH = 16,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic [DATA_WIDTH-1:0] S_TDATA,
  input  logic [KEEP_WIDTH-1:0] S_TKEEP,
  input  logic                  S_TVALID,
  output logic                  S_TREADY,
  input  logic                  S_TLAST,
  input  logic [1:0]            S_TUSER,
  output logic [1599:0]         BLK_DATA,
  output logic                  BLK_VALID,
  input  logic                  BLK_READY,
  output logic                  BLK_FIRST,
  output logic                  BLK_LAST,
  output logic [1:0]            BLK_MODE
);

`ifdef SHA3_KECCAK_LEGACY_PAD_EN
  localparam logic [7:0] DOMAIN_BYTE = 8'h01;
`else
  localparam logic [7:0] DOMAIN_BYTE = 8'h06;
`endif

  localparam logic [1:0] ST_FILL   = 2'd0;
  localparam logic [1:0] ST_PADBLK = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;

  function automatic logic [8:0] rate_of(input logic [1:0] m);
    case (m)
      2'd0:    rate_of = 9'd144;
      2'd1:    rate_of = 9'd136;
      2'd2:    rate_of = 9'd104;
      default: rate_of = 9'd72;
    endcase
  endfunction

  logic [1:0]            state;
  logic [1:0]            state_next;
  logic [1599:0]         block_q;
  logic [7:0]            word_idx;
  logic                  pad_pend;
  logic                  msg_first;
  logic                  msg_active;
  logic [1:0]            mode_q;
  logic                  blk_first_q;
  logic                  blk_last_q;
  logic                  started;

  logic                  beat;
  logic [KEEP_WIDTH-1:0] keep_eff;
  logic [3:0]            pop;
  logic [1:0]            eff_mode;
  logic [8:0]            rate_in;
  logic [8:0]            rate_pad_m1;
  logic [8:0]            n_after;
  logic                  at_full;
  logic                  pad_now;
  logic                  blk_done;
  logic [1599:0]         fill_next;
  logic [1599:0]         pad_block;

  // Keep is only honoured on the last beat; earlier beats are always full.
  assign keep_eff = S_TLAST ? S_TKEEP : {KEEP_WIDTH{1'b1}};
  assign beat     = S_TVALID && S_TREADY;
  // The first beat of a message carries the mode, so size the rate from it.
  assign eff_mode = msg_active ? mode_q : S_TUSER;
  assign rate_in  = rate_of(eff_mode);
  assign rate_pad_m1 = rate_of(mode_q) - 9'd1;

  always_comb begin
    pop = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) pop = pop + 4'(keep_eff[i]);
  end

  assign n_after  = 9'(word_idx) * 9'(KEEP_WIDTH) + 9'(pop);
  assign at_full  = (n_after == rate_in);
  assign pad_now  = S_TLAST && !at_full;
  assign blk_done = beat && (S_TLAST || at_full);

  // Per-byte merge of the incoming beat, with padding folded in when the
  // last beat leaves room in the current block.
  genvar gi;
  generate
    for (gi = 0; gi < 200; gi++) begin : g_byte
      localparam int         LANE = gi % KEEP_WIDTH;
      localparam logic [7:0] WORD = 8'(gi / KEEP_WIDTH);
      localparam logic [8:0] IDX  = 9'(gi);
      logic [7:0] merged;
      always_comb begin
        merged = block_q[8*gi +: 8];
        if ((word_idx == WORD) && keep_eff[LANE]) merged = S_TDATA[8*LANE +: 8];
        if (pad_now && (n_after == IDX))            merged = merged ^ DOMAIN_BYTE;
        if (pad_now && (rate_in - 9'd1 == IDX))     merged = merged ^ 8'h80;
        pad_block[8*gi +: 8] = 8'h00;
        if (gi == 0)                                pad_block[8*gi +: 8] = DOMAIN_BYTE;
        if (rate_pad_m1 == IDX)                     pad_block[8*gi +: 8] = 8'h80;
      end
      assign fill_next[8*gi +: 8] = merged;
    end
  endgenerate

  // State register
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state <= ST_FILL;
    else          state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_FILL:   if (blk_done) state_next = ST_HOLD;
      ST_HOLD:   if (BLK_READY) state_next = pad_pend ? ST_PADBLK : ST_FILL;
      ST_PADBLK: state_next = ST_HOLD;
      default:   state_next = ST_FILL;
    endcase
  end

  // Output logic; S_TREADY depends only on registered state.
  always_comb begin
    S_TREADY  = (state == ST_FILL) && started;
    BLK_VALID = (state == ST_HOLD);
  end

  assign BLK_DATA  = block_q;
  assign BLK_FIRST = blk_first_q;
  assign BLK_LAST  = blk_last_q;
  assign BLK_MODE  = mode_q;

  // Datapath registers
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      block_q     <= '0;
      word_idx    <= '0;
      pad_pend    <= 1'b0;
      msg_first   <= 1'b1;
      msg_active  <= 1'b0;
      mode_q      <= 2'd0;
      blk_first_q <= 1'b0;
      blk_last_q  <= 1'b0;
      started     <= 1'b0;
    end else begin
      started <= 1'b1;
      case (state)
        ST_FILL: begin
          if (beat) begin
            block_q    <= fill_next;
            word_idx   <= word_idx + 8'd1;
            msg_active <= !S_TLAST;
            if (!msg_active) mode_q <= S_TUSER;
            if (blk_done) begin
              blk_first_q <= msg_first;
              msg_first   <= 1'b0;
              blk_last_q  <= pad_now;
              pad_pend    <= S_TLAST && at_full;
            end
          end
        end
        ST_HOLD: begin
          if (BLK_READY) begin
            block_q   <= '0;
            word_idx  <= '0;
            pad_pend  <= 1'b0;
            msg_first <= msg_first | blk_last_q;
          end
        end
        ST_PADBLK: begin
          block_q     <= pad_block;
          blk_first_q <= 1'b0;
          blk_last_q  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sha3_absorb_packer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sha3_absorb_packer
//  Purpose  : Directed self-checking bench for sha3_absorb_packer, DW=16.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sha3_absorb_packer;

  logic          ACLK = 1'b0;
  logic          ARESETN;
  logic [15:0]   S_TDATA;
  logic [1:0]    S_TKEEP;
  logic          S_TVALID;
  logic          S_TREADY;
  logic          S_TLAST;
  logic [1:0]    S_TUSER;
  logic [1599:0] BLK_DATA;
  logic          BLK_VALID;
  logic          BLK_READY;
  logic          BLK_FIRST;
  logic          BLK_LAST;
  logic [1:0]    BLK_MODE;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] msg   [0:199];
  logic [7:0] exp_b [0:199];

  sha3_absorb_packer #(.DATA_WIDTH(16)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_TDATA(S_TDATA), .S_TKEEP(S_TKEEP), .S_TVALID(S_TVALID),
    .S_TREADY(S_TREADY), .S_TLAST(S_TLAST), .S_TUSER(S_TUSER),
    .BLK_DATA(BLK_DATA), .BLK_VALID(BLK_VALID), .BLK_READY(BLK_READY),
    .BLK_FIRST(BLK_FIRST), .BLK_LAST(BLK_LAST), .BLK_MODE(BLK_MODE)
  );

  always #5 ACLK = ~ACLK;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_exp();
    for (int i = 0; i < 200; i++) exp_b[i] = 8'h00;
  endtask

  task automatic send_beat(input logic [15:0] d, input logic [1:0] k,
                           input logic l, input logic [1:0] u);
    int n;
    n = 0;
    S_TDATA = d; S_TKEEP = k; S_TLAST = l; S_TUSER = u; S_TVALID = 1'b1;
    while (!S_TREADY && n < 200) begin
      @(posedge ACLK); #1;
      n++;
    end
    if (!S_TREADY) check_val("tready_timeout", 64'(S_TREADY), 64'd1);
    @(posedge ACLK); #1;
    S_TVALID = 1'b0; S_TLAST = 1'b0; S_TKEEP = 2'b00;
  endtask

  // Sends msg[0..len-1] as one message, then checks the block appears at once.
  task automatic send_msg(input int len, input logic [1:0] mode);
    int nb;
    logic [1:0] k;
    logic [15:0] d;
    nb = (len == 0) ? 1 : (len + 1) / 2;
    for (int b = 0; b < nb; b++) begin
      if (len == 0)               k = 2'b00;
      else if (len - 2 * b >= 2)  k = 2'b11;
      else                        k = 2'b01;
      d = {k[1] ? msg[2*b+1] : 8'h00, k[0] ? msg[2*b] : 8'h00};
      send_beat(d, k, b == nb - 1, mode);
    end
    check_val("valid_latency", 64'(BLK_VALID), 64'd1);
  endtask

  task automatic check_block(input logic first, input logic last, input logic [1:0] mode);
    logic [63:0] lane;
    for (int l = 0; l < 25; l++) begin
      for (int b = 0; b < 8; b++) lane[8*b +: 8] = exp_b[8*l + b];
      check_val($sformatf("data_lane%0d", l), BLK_DATA[64*l +: 64], lane);
    end
    check_val("blk_first", 64'(BLK_FIRST), 64'(first));
    check_val("blk_last",  64'(BLK_LAST),  64'(last));
    check_val("blk_mode",  64'(BLK_MODE),  64'(mode));
  endtask

  task automatic handshake(input logic exp_tready);
    BLK_READY = 1'b1;
    @(posedge ACLK); #1;
    BLK_READY = 1'b0;
    check_val("valid_after_hs",  64'(BLK_VALID), 64'd0);
    check_val("tready_after_hs", 64'(S_TREADY),  64'(exp_tready));
  endtask

  initial begin
    ARESETN = 1'b0; S_TDATA = '0; S_TKEEP = '0; S_TVALID = 1'b0;
    S_TLAST = 1'b0; S_TUSER = '0; BLK_READY = 1'b0;

    // Reset state
    repeat (2) @(posedge ACLK);
    #1;
    check_val("rst_tready", 64'(S_TREADY), 64'd0);
    check_val("rst_valid",  64'(BLK_VALID), 64'd0);
    check_val("rst_first",  64'(BLK_FIRST), 64'd0);
    check_val("rst_last",   64'(BLK_LAST),  64'd0);
    check_val("rst_mode",   64'(BLK_MODE),  64'd0);
    check_val("rst_data",   BLK_DATA[63:0], 64'd0);
    ARESETN = 1'b1;
    #1 check_val("tready_before_edge", 64'(S_TREADY), 64'd0);
    @(posedge ACLK); #1;
    check_val("tready_after_edge", 64'(S_TREADY), 64'd1);

    // Empty message, mode 1
    clear_exp(); exp_b[0] = 8'h06; exp_b[135] = 8'h80;
    send_msg(0, 2'd1);
    check_block(1'b1, 1'b1, 2'd1);
    handshake(1'b1);

    // "abc", mode 1
    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    clear_exp(); exp_b[0] = 8'h61; exp_b[1] = 8'h62; exp_b[2] = 8'h63;
    exp_b[3] = 8'h06; exp_b[135] = 8'h80;
    send_msg(3, 2'd1);
    check_block(1'b1, 1'b1, 2'd1);
    handshake(1'b1);

    // 143-byte message, mode 0: combined pad byte 0x86 in the last rate byte
    clear_exp();
    for (int i = 0; i < 143; i++) begin msg[i] = 8'(i + 1); exp_b[i] = 8'(i + 1); end
    exp_b[143] = 8'h86;
    send_msg(143, 2'd0);
    check_block(1'b1, 1'b1, 2'd0);
    handshake(1'b1);

    // 72-byte message, mode 3: full block, then pad-only block
    clear_exp();
    for (int i = 0; i < 72; i++) begin msg[i] = 8'(3 * i + 5); exp_b[i] = 8'(3 * i + 5); end
    send_msg(72, 2'd3);
    check_block(1'b1, 1'b0, 2'd3);
    handshake(1'b0);
    @(posedge ACLK); #1;
    check_val("padblk_valid", 64'(BLK_VALID), 64'd1);
    check_val("padblk_tready", 64'(S_TREADY), 64'd0);
    clear_exp(); exp_b[0] = 8'h06; exp_b[71] = 8'h80;
    check_block(1'b0, 1'b1, 2'd3);
    handshake(1'b1);

    // Backpressure: 10 cycles of BLK_READY=0, handshake on cycle 11
    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    send_msg(3, 2'd1);
    for (int c = 0; c < 10; c++) begin
      @(posedge ACLK); #1;
      check_val($sformatf("bp_tready%0d", c), 64'(S_TREADY), 64'd0);
      check_val($sformatf("bp_valid%0d", c),  64'(BLK_VALID), 64'd1);
      check_val($sformatf("bp_data%0d", c),   BLK_DATA[63:0], 64'h0000_0000_0663_6261);
    end
    check_val("bp_byte135", 64'(BLK_DATA[8*135 +: 8]), 64'h80);
    handshake(1'b1);

    // Reset mid-message, then an empty mode-2 message
    send_beat(16'h1111, 2'b11, 1'b0, 2'd0);
    send_beat(16'h2222, 2'b11, 1'b0, 2'd0);
    #2 ARESETN = 1'b0;
    #1;
    check_val("midrst_tready", 64'(S_TREADY), 64'd0);
    check_val("midrst_data",   BLK_DATA[63:0], 64'd0);
    @(posedge ACLK); #1;
    ARESETN = 1'b1;
    clear_exp(); exp_b[0] = 8'h06; exp_b[103] = 8'h80;
    send_msg(0, 2'd2);
    check_block(1'b1, 1'b1, 2'd2);
    handshake(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sha3_absorb_packer.md
# sha3_absorb_packer

Upstream input stage of the SHA-3 datapath. Accepts message bytes as an AXI-Stream of `DATA_WIDTH`-bit beats and assembles them into rate-sized blocks. Applies FIPS-202 SHA-3 padding at end of message and presents each block as a 1600-bit lane-ordered state word to the Keccak permutation core. The core's output state then feeds the squeeze/serialiser stage.

## Interface
Parameters:
- `DATA_WIDTH`, 16. Beat width in bits. Legal values: 8, 16, 32, 64.
- `KEEP_WIDTH`, `DATA_WIDTH/8`. Byte-enable width.

Ports:
- `ACLK` in, 1. Single clock; all logic on its rising edge.
- `ARESETN` in, 1. Asynchronous active-low reset.
- `S_TDATA` in, `DATA_WIDTH`. Message beat. Bits [7:0] carry the earliest byte.
- `S_TKEEP` in, `KEEP_WIDTH`. Byte enables, contiguous from bit 0. Only meaningful on the `S_TLAST` beat; all-ones is implied on other beats.
- `S_TVALID` in, 1. Beat valid.
- `S_TREADY` out, 1. Beat accepted when `S_TVALID && S_TREADY`.
- `S_TLAST` in, 1. Final beat of message.
- `S_TUSER` in, 2. Digest mode: 0 = 224, 1 = 256, 2 = 384, 3 = 512. Sampled on the first beat of a message only.
- `BLK_DATA` out, 1600. Block; byte *i* of the block sits at bits [8i+7:8i]. Capacity bits are 0.
- `BLK_VALID` out, 1. Block available.
- `BLK_READY` in, 1. Core accepts block.
- `BLK_FIRST` out, 1. Block is the first of its message; the core zeroes its state before absorbing.
- `BLK_LAST` out, 1. Block is the final (padded) block of its message.
- `BLK_MODE` out, 2. Latched `S_TUSER` of the message.

## Operation
- Rate bytes R: mode 0 → 144, 1 → 136, 2 → 104, 3 → 72. Words per block W = R*8/`DATA_WIDTH`.
- States: FILL, PADBLK, HOLD.
- **FILL**
  - `S_TREADY`=1. An accepted beat *k* is XOR-free written to block bits [k*DW +: DW], masked by keep; byte counter advances by popcount(keep).
  - A non-last beat with k = W−1 → HOLD, `BLK_LAST`=0.
  - A last beat leaving byte count n < R: pad in place, → HOLD, `BLK_LAST`=1.
    - Byte n ^= 0x06; byte R−1 ^= 0x80.
    - If n = R−1, that byte becomes 0x86.
  - A last beat leaving n = R exactly: → HOLD with `BLK_LAST`=0 and the pad-pending flag set.
- **HOLD**
  - `S_TREADY`=0; `BLK_VALID`=1. `BLK_DATA`, `BLK_FIRST`, `BLK_LAST`, and `BLK_MODE` are stable until handshake.
  - On `BLK_VALID && BLK_READY`: the block register is cleared and the word index is reset.
  - If pad pending → PADBLK; otherwise → FILL.
  - The next message's first block asserts `BLK_FIRST` when the preceding block had `BLK_LAST`.
- **PADBLK**
  - One cycle; builds byte 0 = 0x06, byte R−1 = 0x80, rest 0, `BLK_FIRST`=0, `BLK_LAST`=1. → HOLD.
- Empty message: a single `S_TLAST` beat with `S_TKEEP`=0 yields one block with byte 0 = 0x06.
- `S_TKEEP`=0 on a non-last beat is a protocol error; the beat is treated as all-ones.
- Reset (any state, asynchronous)
  - State=FILL; block register, counters, and pad flag cleared.
  - `BLK_FIRST` internal flag set.
  - A partial message is discarded.

## Timing
- Reset values: `S_TREADY`=0 while `ARESETN`=0 and 1 from the first edge after release; `BLK_VALID`=0, `BLK_FIRST`=0, `BLK_LAST`=0, `BLK_MODE`=0, `BLK_DATA`=0.
- Latency: `BLK_VALID` rises the cycle after the completing beat is accepted.
- After handshake, `S_TREADY` returns to 1 the next cycle. Throughput is W+1 cycles per block at zero backpressure.
- The pad-only block appears 2 cycles after the prior block's handshake (PADBLK, then HOLD).
- `BLK_VALID` never drops without `BLK_READY`. No combinational path from `BLK_READY` to `S_TREADY`.

## Configuration
- `SHA3_KECCAK_LEGACY_PAD_EN`: when defined, the domain-separation byte is 0x01 instead of 0x06, giving original Keccak. The n = R−1 combined byte then becomes 0x81. Otherwise FIPS-202 SHA-3 padding, as above.

## Test plan
- Empty message, mode 1 (`S_TKEEP`=0, `S_TLAST`) → one block: byte 0 = 0x06, byte 135 = 0x80, rest 0, `BLK_FIRST`=`BLK_LAST`=1, `BLK_MODE`=1.
- "abc", mode 1, DW=16: beats 0x6261 keep 11, then 0x0063 keep 01 with `S_TLAST` → bytes 0..3 = 61 62 63 06, byte 135 = 0x80.
- 143-byte message, mode 0, DW=16 (72 beats, last beat keep 01) → single block, byte 143 = 0x86.
- 72-byte message, mode 3 (36 beats) → block 1 with `BLK_LAST`=0, then pad block with byte 0 = 0x06, byte 71 = 0x80, `BLK_LAST`=1.
- Hold `BLK_READY`=0 for 10 cycles → `S_TREADY`=0 throughout, `BLK_DATA` unchanged, handshake on cycle 11.
- Assert `ARESETN`=0 mid-message, then send an empty mode-2 message → only the new block is emitted, with `BLK_FIRST`=1 and byte 103 = 0x80.
